// File: rtl/gridwalk_move_sched_pkg.sv
// Shared definitions for the grid-walker move scheduler: direction codes,
// FSM state encoding and default sizing.
package gridwalk_pkg;

    localparam logic [1:0] DIR_PX = 2'b00;
    localparam logic [1:0] DIR_MX = 2'b01;
    localparam logic [1:0] DIR_PY = 2'b10;
    localparam logic [1:0] DIR_MY = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_GAP   = 16;
    localparam int DEF_GRID  = 8;

endpackage

// File: rtl/gridwalk_move_fifo.sv
// DEPTH x 2-bit synchronous move FIFO; push and pop in one cycle are both honoured.
module gridwalk_move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [1:0]                     push_data,
    input  logic                           pop,
    output logic [1:0]                     head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gridwalk_move_sched.sv
// Move scheduler: arbitrates rotor/replay moves into a FIFO, issues spaced steps
// to the walker, tracks position and counts discarded moves.
module gridwalk_move_sched
    import gridwalk_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP   = DEF_GAP,
    parameter int GRID  = DEF_GRID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      rot_event,
    input  logic [1:0]                rot_dir,
    input  logic                      rp_valid,
    input  logic [1:0]                rp_dir,
    output logic                      rp_ready,
    output logic                      step_pulse,
    output logic [1:0]                step_dir,
    output logic [$clog2(GRID)-1:0]   pos_x,
    output logic [$clog2(GRID)-1:0]   pos_y,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);

    localparam int PW = $clog2(GRID);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(GAP);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [PW-1:0] EDGE      = PW'(GRID - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'((GAP > 2) ? GAP - 3 : 0);

    logic [CW-1:0] count;
    logic [1:0]    head;
    logic          full;
    logic          rot_drop;
    logic          push;
    logic [1:0]    push_data;
    logic          pop;
    logic          off_grid;
    logic [PW-1:0] nx;
    logic [PW-1:0] ny;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;
    state_t        state;
    logic [WW-1:0] wait_cnt;

    // Rotor event owns the write port whenever it pulses, even when full (it is then dropped).
    assign full      = (count == FULL);
    assign rp_ready  = rst_n && !rot_event && !full;
    assign rot_drop  = rot_event && full;
    assign push      = (rot_event && !full) || (rp_valid && rp_ready);
    assign push_data = rot_event ? rot_dir : rp_dir;
    assign pop       = (state == S_IDLE) && enable && (count != '0);
    assign busy      = (count != '0) || (state != S_IDLE);

    gridwalk_move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        nx       = pos_x;
        ny       = pos_y;
        off_grid = 1'b0;
        unique case (head)
            DIR_PX: begin off_grid = (pos_x == EDGE); nx = pos_x + PW'(1); end
            DIR_MX: begin off_grid = (pos_x == '0);   nx = pos_x - PW'(1); end
            DIR_PY: begin off_grid = (pos_y == EDGE); ny = pos_y + PW'(1); end
            DIR_MY: begin off_grid = (pos_y == '0);   ny = pos_y - PW'(1); end
        endcase
    end

    always_comb begin
        drop_inc = {1'b0, rot_drop} + {1'b0, pop && off_grid};
        drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[8] ? '1 : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            step_pulse <= 1'b0;
            step_dir   <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
        end else begin
            step_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pop && !off_grid) begin
                        state      <= S_ISSUE;
                        step_pulse <= 1'b1;
                        step_dir   <= head;
                        pos_x      <= nx;
                        pos_y      <= ny;
                    end
                end
                // ISSUE + (GAP-2) WAIT + one IDLE pop cycle spaces pulses GAP apart.
                S_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= (GAP > 2) ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gridwalk_move_sched.sv
// Directed bench for gridwalk_move_sched with a queue-based timing model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_gridwalk_move_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int GRID  = 8;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rot_event;
    logic [1:0] rot_dir;
    logic       rp_valid;
    logic [1:0] rp_dir;
    logic       rp_ready;
    logic       step_pulse;
    logic [1:0] step_dir;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [7:0] drop_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    gridwalk_move_sched #(.DEPTH(DEPTH), .GAP(GAP), .GRID(GRID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rot_event  (rot_event),
        .rot_dir    (rot_dir),
        .rp_valid   (rp_valid),
        .rp_dir     (rp_dir),
        .rp_ready   (rp_ready),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: queue of pending moves, position, drop count and the earliest
    // clock edge at which the next step may be taken.
    logic [1:0] mq[$];
    int         m_x, m_y, m_drop;
    logic [1:0] m_dir;
    bit         m_pulse, m_busy;
    longint     m_edge, m_next;
    int         pre, nx, ny;
    logic [1:0] d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_x = 0; m_y = 0; m_drop = 0; m_dir = 2'b00;
            m_pulse = 0; m_busy = 0; m_edge = 0; m_next = 0;
        end else begin
            pre = mq.size();
            m_pulse = 0;
            if (enable && pre > 0 && m_edge >= m_next) begin
                d = mq.pop_front();
                nx = m_x; ny = m_y;
                case (d)
                    2'b00: nx = nx + 1;
                    2'b01: nx = nx - 1;
                    2'b10: ny = ny + 1;
                    default: ny = ny - 1;
                endcase
                if (nx < 0 || nx >= GRID || ny < 0 || ny >= GRID) begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end else begin
                    m_x = nx; m_y = ny; m_pulse = 1; m_dir = d;
                    m_next = m_edge + GAP;
                end
            end
            if (rot_event) begin
                if (pre == DEPTH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else mq.push_back(rot_dir);
            end else if (rp_valid && pre < DEPTH) begin
                mq.push_back(rp_dir);
            end
            m_busy = (mq.size() > 0) || (m_edge < m_next - 1);
            m_edge++;
        end
    end

    int         p_cyc[$];
    logic [1:0] p_dir[$];

    always @(negedge clk) begin
        if (rst_n) begin
            check("step_pulse", int'(step_pulse), int'(m_pulse));
            check("step_dir", int'(step_dir), int'(m_dir));
            check("pos_x", int'(pos_x), m_x);
            check("pos_y", int'(pos_y), m_y);
            check("drop_cnt", int'(drop_cnt), m_drop);
            check("busy", int'(busy), int'(m_busy));
            check("rp_ready", int'(rp_ready), int'(!rot_event && mq.size() < DEPTH));
            if (step_pulse) begin
                p_cyc.push_back(cyc);
                p_dir.push_back(step_dir);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; rot_event = 1'b0; rot_dir = 2'b00;
        rp_valid = 1'b0; rp_dir = 2'b00;
        tick(2);
        rst_n = 1'b1;
        p_cyc.delete();
        p_dir.delete();
        tick(1);
    endtask

    task automatic rot_pulse(input logic [1:0] dir);
        rot_event = 1'b1; rot_dir = dir;
        tick(1);
        rot_event = 1'b0;
    endtask

    int e0;

    initial begin
        rst_n = 1'b0; enable = 1'b1; rot_event = 1'b0; rot_dir = 2'b00;
        rp_valid = 1'b0; rp_dir = 2'b00;
        #2;
        check("reset_rp_ready", int'(rp_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_drop", int'(drop_cnt), 0);

        // 1: single +x rotor move, step two cycles after the event
        do_reset();
        rot_pulse(2'b00);
        check("t1_no_pulse_t1", int'(step_pulse), 0);
        tick(1);
        check("t1_pulse_t2", int'(step_pulse), 1);
        check("t1_dir", int'(step_dir), 0);
        check("t1_pos_x", int'(pos_x), 1);
        check("t1_pos_y", int'(pos_y), 0);
        check("t1_drop", int'(drop_cnt), 0);
        tick(GAP);

        // 2: off-grid -x at origin is discarded
        do_reset();
        rot_pulse(2'b01);
        tick(1);
        check("t2_drop", int'(drop_cnt), 1);
        check("t2_busy", int'(busy), 0);
        check("t2_pos_x", int'(pos_x), 0);
        tick(4);
        check("t2_no_steps", p_cyc.size(), 0);

        // 3: six back-to-back +y rotor moves; the sixth finds the FIFO full
        do_reset();
        for (int i = 0; i < 6; i++) rot_pulse(2'b10);
        tick(5 * GAP + 4);
        check("t3_drop", int'(drop_cnt), 1);
        check("t3_steps", p_cyc.size(), 5);
        for (int i = 1; i < p_cyc.size(); i++) check("t3_spacing", p_cyc[i] - p_cyc[i-1], GAP);
        check("t3_pos_x", int'(pos_x), 0);
        check("t3_pos_y", int'(pos_y), 5);

        // 4: rotor and replay collide; rotor wins, replay accepted next cycle
        do_reset();
        rp_valid = 1'b1; rp_dir = 2'b00; rot_event = 1'b1; rot_dir = 2'b10;
        @(negedge clk);
        check("t4_rp_ready_blocked", int'(rp_ready), 0);
        @(posedge clk); #1;
        rot_event = 1'b0;
        @(negedge clk);
        check("t4_rp_ready_next", int'(rp_ready), 1);
        @(posedge clk); #1;
        rp_valid = 1'b0;
        tick(2 * GAP + 4);
        check("t4_steps", p_cyc.size(), 2);
        if (p_dir.size() == 2) begin
            check("t4_first_dir", int'(p_dir[0]), 2);
            check("t4_second_dir", int'(p_dir[1]), 0);
        end
        check("t4_pos_x", int'(pos_x), 1);
        check("t4_pos_y", int'(pos_y), 1);

        // 5: hold with enable low, then release and check step timing
        do_reset();
        enable = 1'b0;
        rp_valid = 1'b1; rp_dir = 2'b00;
        tick(3);
        rp_valid = 1'b0;
        tick(5);
        check("t5_busy_held", int'(busy), 1);
        check("t5_no_steps_held", p_cyc.size(), 0);
        enable = 1'b1;
        e0 = cyc;
        tick(3 * GAP + 4);
        check("t5_steps", p_cyc.size(), 3);
        if (p_cyc.size() == 3) begin
            check("t5_step0_time", p_cyc[0] - e0, 1);
            check("t5_step1_time", p_cyc[1] - e0, 17);
            check("t5_step2_time", p_cyc[2] - e0, 33);
        end
        check("t5_pos_x", int'(pos_x), 3);
        check("t5_pos_y", int'(pos_y), 0);

        // 6: reset mid-WAIT aborts and flushes
        do_reset();
        rot_pulse(2'b00);
        rot_pulse(2'b00);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_pos_x", int'(pos_x), 0);
        check("t6_pos_y", int'(pos_y), 0);
        check("t6_pulse", int'(step_pulse), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_rp_ready", int'(rp_ready), 0);
        tick(2);
        rst_n = 1'b1;
        p_cyc.delete();
        p_dir.delete();
        tick(2 * GAP + 4);
        check("t6_no_steps", p_cyc.size(), 0);
        check("t6_busy_after", int'(busy), 0);

        // 7: drop counter saturates
        do_reset();
        for (int i = 0; i < 300; i++) rot_pulse(2'b01);
        tick(3);
        check("t7_drop_sat", int'(drop_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
